// File: rtl/rr_mux_select_arbiter.sv
// Round-robin, burst-limited arbiter that drives the swapped-bit select of the
// downstream two-level 4:1 mux and a valid/ready handshake toward its consumer.
module rr_mux_select_arbiter #(
    parameter int BURST = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [1:0] select,
    output logic [3:0] grant
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] LAST_COUNT = 4'(BURST - 1);

    state_t     state_r;
    logic [1:0] owner_r;
    logic [1:0] ptr_r;
    logic [3:0] count_r;

    logic       xfer_s;
    logic       release_s;
    logic [1:0] arb_base_s;
    logic [2:0] arb_s;
    logic       win_found_s;
    logic [1:0] win_idx_s;

    // First set request at or after base, wrapping; {found, index}.
    // Scanned from the farthest offset down so the nearest one is kept.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [2:0] pick;
        logic [1:0] idx;
        pick = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = base + 2'(i);
            if (r[idx]) begin
                pick = {1'b1, idx};
            end
        end
        return pick;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // The downstream mux wants the pair bit in select[0]: a=00, b=10, c=01, d=11.
    function automatic logic [1:0] mux_code(input logic [1:0] idx);
        return {idx[0], idx[1]};
    endfunction

    // Handshake, release decision and re-arbitration base for this cycle.
    always_comb begin
        out_valid  = 1'b0;
        xfer_s     = 1'b0;
        release_s  = 1'b0;
        arb_base_s = ptr_r;
        if (state_r == GRANT) begin
            out_valid  = req[owner_r];
            xfer_s     = req[owner_r] && out_ready;
            release_s  = !req[owner_r] || (xfer_s && (count_r == LAST_COUNT));
            arb_base_s = owner_r + 2'd1;
        end else begin
            out_valid  = 1'b0;
            xfer_s     = 1'b0;
            release_s  = 1'b0;
            arb_base_s = ptr_r;
        end
        arb_s       = rr_pick(req, arb_base_s);
        win_found_s = arb_s[2];
        win_idx_s   = arb_s[1:0];
    end

    // Arbiter FSM with registered select and grant; a release re-arbitrates
    // in the same edge so ownership passes without a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            owner_r <= 2'd0;
            ptr_r   <= 2'd0;
            count_r <= 4'd0;
            select  <= 2'b00;
            grant   <= 4'b0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (win_found_s) begin
                        state_r <= GRANT;
                        owner_r <= win_idx_s;
                        count_r <= 4'd0;
                        select  <= mux_code(win_idx_s);
                        grant   <= onehot(win_idx_s);
                    end else begin
                        state_r <= IDLE;
                        grant   <= 4'b0000;
                    end
                end
                GRANT: begin
                    if (release_s) begin
                        ptr_r <= owner_r + 2'd1;
                        if (win_found_s) begin
                            state_r <= GRANT;
                            owner_r <= win_idx_s;
                            count_r <= 4'd0;
                            select  <= mux_code(win_idx_s);
                            grant   <= onehot(win_idx_s);
                        end else begin
                            state_r <= IDLE;
                            count_r <= 4'd0;
                            grant   <= 4'b0000;
                        end
                    end else if (xfer_s) begin
                        count_r <= count_r + 4'd1;
                    end else begin
                        count_r <= count_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    grant   <= 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_mux_select_arbiter.sv
// Scoreboard bench for rr_mux_select_arbiter: a BURST=4 and a BURST=2 instance
// run side by side against a behavioural model plus directed constant checks.
module tb_rr_mux_select_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req4, req2;
    logic       rdy4, rdy2;
    logic       val4, val2;
    logic [1:0] sel4, sel2;
    logic [3:0] gnt4, gnt2;

    int n_vec;
    int n_err;

    typedef struct packed {
        logic       gs;
        logic [1:0] own;
        logic [1:0] ptr;
        logic [1:0] sel;
        logic [3:0] cnt;
    } mdl_t;

    typedef struct packed {
        logic [3:0] g4;
        logic [1:0] s4;
        logic [3:0] g2;
        logic [1:0] s2;
    } exp_t;

    mdl_t m4, m2;
    exp_t sb[$];

    logic [1:0] fair_sel [8] = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b11};
    logic [3:0] fair_gnt [8] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010,
                                 4'b0100, 4'b0100, 4'b1000, 4'b1000};

    rr_mux_select_arbiter #(.BURST(4)) u4 (
        .clk(clk), .reset(reset), .req(req4), .out_ready(rdy4),
        .out_valid(val4), .select(sel4), .grant(gnt4)
    );

    rr_mux_select_arbiter #(.BURST(2)) u2 (
        .clk(clk), .reset(reset), .req(req2), .out_ready(rdy2),
        .out_valid(val2), .select(sel2), .grant(gnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour for one rising edge.
    function automatic mdl_t mdl_step(input mdl_t m, input logic [3:0] r, input logic rdy, input int b);
        mdl_t n;
        logic arb;
        logic took;
        int   base;
        int   j;
        n    = m;
        arb  = 1'b1;
        base = int'(m.ptr);
        if (m.gs) begin
            took = r[m.own] && rdy;
            if (took) n.cnt = m.cnt + 4'd1;
            arb = !r[m.own] || (took && (int'(m.cnt) == b - 1));
            if (arb) begin
                n.ptr = m.own + 2'd1;
                base  = int'(n.ptr);
            end
        end
        if (arb) begin
            n.gs = 1'b0;
            for (int k = 0; k < 4; k++) begin
                j = (base + k) % 4;
                if (!n.gs && r[j]) begin
                    n.gs  = 1'b1;
                    n.own = 2'(j);
                    n.cnt = 4'd0;
                    n.sel = {n.own[0], n.own[1]};
                end
            end
        end
        return n;
    endfunction

    function automatic logic [3:0] mdl_grant(input mdl_t m);
        return m.gs ? (4'b0001 << m.own) : 4'b0000;
    endfunction

    function automatic logic mdl_valid(input mdl_t m, input logic [3:0] r);
        return m.gs && r[m.own];
    endfunction

    // Drive inputs on the falling edge and compare against the queued expectation.
    task automatic apply(input logic [3:0] r4, input logic d4, input logic [3:0] r2, input logic d2);
        exp_t e;
        @(negedge clk);
        req4 = r4; rdy4 = d4; req2 = r2; rdy2 = d2;
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 8'd0, 8'd1);
        end else begin
            e = sb.pop_front();
            check("u4_grant", {4'd0, gnt4}, {4'd0, e.g4});
            check("u4_select", {6'd0, sel4}, {6'd0, e.s4});
            check("u2_grant", {4'd0, gnt2}, {4'd0, e.g2});
            check("u2_select", {6'd0, sel2}, {6'd0, e.s2});
        end
        check("u4_valid", {7'd0, val4}, {7'd0, mdl_valid(m4, req4)});
        check("u2_valid", {7'd0, val2}, {7'd0, mdl_valid(m2, req2)});
    endtask

    task automatic advance();
        @(posedge clk);
        m4 = mdl_step(m4, req4, rdy4, 4);
        m2 = mdl_step(m2, req2, rdy2, 2);
        sb.push_back('{g4: mdl_grant(m4), s4: m4.sel, g2: mdl_grant(m2), s2: m2.sel});
    endtask

    task automatic model_reset();
        m4 = '0;
        m2 = '0;
        sb.delete();
        sb.push_back('0);
    endtask

    task automatic step(input logic [3:0] r4, input logic d4, input logic [3:0] r2, input logic d2);
        apply(r4, d4, r2, d2);
        advance();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        req4 = 4'd0; rdy4 = 1'b0; req2 = 4'd0; rdy2 = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // Fairness on BURST=2 while the BURST=4 instance serves c alone.
        for (int i = 0; i < 10; i++) begin
            apply(4'b0100, 1'b1, 4'b1111, 1'b1);
            if (i >= 1) begin
                check("fair_sel", {6'd0, sel2}, {6'd0, fair_sel[(i - 1) % 8]});
                check("fair_grant", {4'd0, gnt2}, {4'd0, fair_gnt[(i - 1) % 8]});
                check("fair_valid", {7'd0, val2}, 8'd1);
                check("sole_sel", {6'd0, sel4}, 8'h01);
                check("sole_valid", {7'd0, val4}, 8'd1);
            end
            advance();
        end
        step(4'b0000, 1'b1, 4'b0000, 1'b1);
        step(4'b0000, 1'b1, 4'b0000, 1'b1);

        // Backpressure: a gets one transfer, stalls 10 cycles, then 3 more.
        step(4'b0011, 1'b1, 4'b0000, 1'b0);
        apply(4'b0011, 1'b1, 4'b0000, 1'b0);
        check("bp_first_grant", {4'd0, gnt4}, 8'h01);
        advance();
        for (int i = 0; i < 10; i++) begin
            apply(4'b0011, 1'b0, 4'b0000, 1'b0);
            check("bp_hold_grant", {4'd0, gnt4}, 8'h01);
            check("bp_hold_sel", {6'd0, sel4}, 8'h00);
            advance();
        end
        for (int i = 0; i < 3; i++) begin
            apply(4'b0011, 1'b1, 4'b0000, 1'b0);
            check("bp_tail_sel", {6'd0, sel4}, 8'h00);
            check("bp_tail_valid", {7'd0, val4}, 8'd1);
            advance();
        end
        apply(4'b0011, 1'b1, 4'b0000, 1'b0);
        check("bp_handoff_sel", {6'd0, sel4}, 8'h02);
        advance();

        // Early drop of owner b while d also requests.
        apply(4'b1001, 1'b1, 4'b0000, 1'b0);
        check("drop_valid", {7'd0, val4}, 8'd0);
        advance();
        for (int i = 0; i < 4; i++) begin
            apply(4'b1000, 1'b1, 4'b0000, 1'b0);
            check("drop_grant", {4'd0, gnt4}, 8'h08);
            check("drop_sel", {6'd0, sel4}, 8'h03);
            advance();
        end

        // Empty release: sole requester drops after its burst.
        apply(4'b0000, 1'b1, 4'b0000, 1'b0);
        check("empty_valid", {7'd0, val4}, 8'd0);
        advance();
        apply(4'b0000, 1'b1, 4'b0000, 1'b0);
        check("empty_grant", {4'd0, gnt4}, 8'h00);
        check("empty_sel_hold", {6'd0, sel4}, 8'h03);
        advance();

        // Asynchronous reset in the middle of a grant.
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b1, 4'b1111, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("rst_valid", {6'd0, val4, val2}, 8'd0);
        check("rst_grant", {gnt4, gnt2}, 8'd0);
        check("rst_sel", {4'd0, sel4, sel2}, 8'd0);
        #1 reset = 1'b0;
        model_reset();
        step(4'b1000, 1'b1, 4'b0000, 1'b0);
        apply(4'b1000, 1'b1, 4'b0000, 1'b0);
        check("post_rst_grant", {4'd0, gnt4}, 8'h08);
        check("post_rst_sel", {6'd0, sel4}, 8'h03);
        advance();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
